// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg: shared widths, bank select encodings, bank depths and FSM states for the layer-memory responder
package cnn_mem_pkg;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 20;
    localparam int IMG_DEPTH = 4096;
    localparam int L0_DEPTH  = 4096;
    localparam int L1_DEPTH  = 1024;
    localparam int L2_DEPTH  = 2048;
    localparam int N_BANKS   = 5;

    typedef enum logic [2:0] {
        NO_MEM   = 3'd0,
        MEM_L0K0 = 3'd1,
        MEM_L0K1 = 3'd2,
        MEM_L1K0 = 3'd3,
        MEM_L1K1 = 3'd4,
        MEM_L2   = 3'd5
    } csel_t;

    typedef enum logic [1:0] {IDLE, REQ, RUN, CMPL} state_t;

    // Illegal selects report depth 0, so a single range check also rejects them
    function automatic int bank_depth(logic [2:0] sel);
        return (sel == MEM_L0K0 || sel == MEM_L0K1) ? L0_DEPTH :
               (sel == MEM_L1K0 || sel == MEM_L1K1) ? L1_DEPTH :
               (sel == MEM_L2) ? L2_DEPTH : 0;
    endfunction

    function automatic logic in_range(logic [ADDR_W-1:0] a, int depth);
        return int'(a) < depth;
    endfunction
endpackage

// File: rtl/cnn_sp_ram.sv
// cnn_sp_ram: one-write one-read synchronous RAM with registered, enabled read (read-before-write)
module cnn_sp_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 20,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk or posedge reset)
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/cnn_layer_mem_responder.sv
// cnn_layer_mem_responder: image/result memories, start handshake FSM, host load and dump ports
// Optional CNN_MEM_ERR_CNT_EN adds err_cnt, a saturating count of cycles with dropped requests.
module cnn_layer_mem_responder
    import cnn_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic [2:0]        csel,
    input  logic              dump_rd,
    input  logic [2:0]        dump_sel,
    input  logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              done,
`ifdef CNN_MEM_ERR_CNT_EN
    output logic [15:0]       err_cnt,
`endif
    output logic [1:0]        state_o
);
    state_t state, state_nx;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (start ? REQ : IDLE) :
                   (state == REQ)  ? (busy ? RUN : REQ) :
                   (state == RUN)  ? (busy ? RUN : CMPL) : IDLE;

    always_comb begin
        ready   = state == REQ;
        done    = state == CMPL;
        state_o = state;
    end

    logic idle, run, ld_ok, wr_ok, rd_ok, dump_ok, dump_take, dump_go;
    assign idle    = state == IDLE;
    assign run     = state == RUN;
    assign ld_ok   = ld_valid && idle && in_range(ld_addr, IMG_DEPTH);
    assign wr_ok   = cwr && run && in_range(caddr_wr, bank_depth(csel));
    assign rd_ok   = crd && in_range(caddr_rd, bank_depth(csel));
    assign dump_ok = dump_rd && idle && in_range(dump_addr, bank_depth(dump_sel));
    // Each bank has one read port; a same-bank crd wins and the dump is dropped that cycle
    assign dump_take = dump_rd && idle && !(rd_ok && dump_ok && csel == dump_sel);
    assign dump_go   = dump_take && dump_ok;

    cnn_sp_ram #(.DEPTH(IMG_DEPTH), .DATA_W(DATA_W)) u_img (
        .clk, .reset,
        .we(ld_ok), .waddr(ld_addr), .wdata(ld_data),
        .re(1'b1), .raddr(iaddr), .rdata(idata)
    );

    logic [DATA_W-1:0] bank_q [1:N_BANKS];

    for (genvar b = 1; b <= N_BANKS; b++) begin : g_bank
        localparam int D  = bank_depth(3'(b));
        localparam int AW = $clog2(D);
        logic c_take;
        assign c_take = rd_ok && csel == 3'(b);
        cnn_sp_ram #(.DEPTH(D), .DATA_W(DATA_W)) u_ram (
            .clk, .reset,
            .we(wr_ok && csel == 3'(b)), .waddr(caddr_wr[AW-1:0]), .wdata(cdata_wr),
            .re(c_take || (dump_go && dump_sel == 3'(b))),
            .raddr(c_take ? caddr_rd[AW-1:0] : dump_addr[AW-1:0]),
            .rdata(bank_q[b])
        );
    end

    // RAM outputs are shared, so each reader keeps its own copy to hold across idle cycles
    logic              c_hit, d_hit;
    logic [2:0]        c_sel, d_sel;
    logic [DATA_W-1:0] c_hold, d_hold, c_word, d_word;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            c_hit  <= 1'b0;
            d_hit  <= 1'b0;
            c_sel  <= NO_MEM;
            d_sel  <= NO_MEM;
            c_hold <= '0;
            d_hold <= '0;
        end else begin
            c_hit  <= crd;
            d_hit  <= dump_take;
            c_hold <= cdata_rd;
            d_hold <= dump_data;
            if (crd) c_sel <= rd_ok ? csel : NO_MEM;
            if (dump_take) d_sel <= dump_ok ? dump_sel : NO_MEM;
        end

    always_comb begin
        c_word = '0;
        d_word = '0;
        for (int i = 1; i <= N_BANKS; i++) begin
            if (c_sel == 3'(i)) c_word = bank_q[i];
            if (d_sel == 3'(i)) d_word = bank_q[i];
        end
        cdata_rd  = c_hit ? c_word : c_hold;
        dump_data = d_hit ? d_word : d_hold;
    end

`ifdef CNN_MEM_ERR_CNT_EN
    logic drop;
    assign drop = (cwr && !wr_ok) || (crd && !rd_ok) || (ld_valid && !ld_ok) || (dump_rd && !dump_go);

    always_ff @(posedge clk or posedge reset)
        if (reset) err_cnt <= '0;
        else if (idle && start) err_cnt <= '0;
        else if (drop && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
endmodule
